// File: rtl/eth_tx_framer.sv
// eth_tx_framer: wraps a valid/ready payload stream into a GMII Ethernet frame.
// Define ETH_TX_FCS_EN to build the CRC-32 generator and append the 4-byte FCS.
module eth_tx_framer #(
  parameter logic [47:0] DEST_MAC     = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC      = 48'h072227acdb65,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PAYLOAD  = 46,
  parameter int unsigned MAX_PAYLOAD  = 1500,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic [15:0] s_len_type,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy
);
  localparam int unsigned   PW       = $clog2(MAX_PAYLOAD + 1);
  localparam logic [15:0]   PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0]   IFG_LAST = 16'(IFG_LEN - 2);
  localparam logic [PW-1:0] MIN_P    = PW'(MIN_PAYLOAD);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DST, SRC, LEN, PAYLOAD, PAD, FCS, IFG, DROP
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   cnt, cnt_nx;
  logic [PW-1:0] pay, pay_nx;
  logic [15:0]   len_type, len_type_nx;
  logic [7:0]    txd_nx;
  logic          en_nx, er_nx;

  // The IDLE cycle that samples s_valid is the last gap cycle, so IFG holds IFG_LEN-1 cycles.
  function automatic state_t gap_state();
    if (IFG_LEN > 1) return IFG;
    else return IDLE;
  endfunction

  function automatic state_t tail_state();
`ifdef ETH_TX_FCS_EN
    return FCS;
`else
    return gap_state();
`endif
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    case (i)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc;
  logic        crc_upd;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // CRC follows the byte being registered onto gmii_txd; error cycles are excluded.
  assign crc_upd = en_nx & ~er_nx & (state inside {DST, SRC, LEN, PAYLOAD, PAD});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                crc <= '1;
    else if (state == IDLE) crc <= '1;
    else if (crc_upd)       crc <= crc_step(crc, txd_nx);
  end
`endif

  assign s_ready = (state == PAYLOAD) || (state == DROP);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pay_nx      = pay;
    len_type_nx = len_type;
    txd_nx      = '0;
    en_nx       = 1'b0;
    er_nx       = 1'b0;
    case (state)
      IDLE: begin
        pay_nx = '0;
        if (s_valid) begin
          len_type_nx = s_len_type;
          state_nx    = PREAMBLE;
        end
      end
      PREAMBLE: begin
        txd_nx = 8'h55;
        en_nx  = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == PRE_LAST) state_nx = SFD;
      end
      SFD: begin
        txd_nx   = 8'hD5;
        en_nx    = 1'b1;
        state_nx = DST;
      end
      DST: begin
        txd_nx = mac_byte(DEST_MAC, cnt[2:0]);
        en_nx  = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == 16'd5) state_nx = SRC;
      end
      SRC: begin
        txd_nx = mac_byte(SRC_MAC, cnt[2:0]);
        en_nx  = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == 16'd5) state_nx = LEN;
      end
      LEN: begin
        txd_nx = cnt[0] ? len_type[7:0] : len_type[15:8];
        en_nx  = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == 16'd1) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        en_nx = 1'b1;
        if (!s_valid) begin
          er_nx    = 1'b1;
          state_nx = DROP;
        end else if (pay == MAX_P) begin
          // Oversize byte is swallowed; if it already carries s_last there is nothing left to drop.
          er_nx    = 1'b1;
          state_nx = s_last ? gap_state() : DROP;
        end else begin
          txd_nx = s_data;
          pay_nx = pay + 1'b1;
          if (s_last) state_nx = (pay_nx < MIN_P) ? PAD : tail_state();
        end
      end
      PAD: begin
        en_nx  = 1'b1;
        pay_nx = pay + 1'b1;
        if (pay_nx >= MIN_P) state_nx = tail_state();
      end
`ifdef ETH_TX_FCS_EN
      FCS: begin
        en_nx  = 1'b1;
        cnt_nx = cnt + 1'b1;
        case (cnt[1:0])
          2'd0:    txd_nx = ~crc[7:0];
          2'd1:    txd_nx = ~crc[15:8];
          2'd2:    txd_nx = ~crc[23:16];
          default: txd_nx = ~crc[31:24];
        endcase
        if (cnt == 16'd3) state_nx = gap_state();
      end
`endif
      IFG: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == IFG_LAST) state_nx = IDLE;
      end
      DROP: begin
        if (s_valid && s_last) state_nx = gap_state();
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pay        <= '0;
      len_type   <= '0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pay        <= pay_nx;
      len_type   <= len_type_nx;
      gmii_txd   <= txd_nx;
      gmii_tx_en <= en_nx;
      gmii_tx_er <= er_nx;
      busy       <= (state_nx != IDLE);
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: framing, padding, gap, underrun, oversize, mid-frame reset.
// FCS-dependent expectations follow ETH_TX_FCS_EN.
module tb_eth_tx_framer;
`ifdef ETH_TX_FCS_EN
  localparam int FCSN = 4;
`else
  localparam int FCSN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] s_len_type;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  eth_tx_framer #(
    .DEST_MAC(48'h023528fbdd66), .SRC_MAC(48'h072227acdb65), .PREAMBLE_LEN(7),
    .MIN_PAYLOAD(46), .MAX_PAYLOAD(1500), .IFG_LEN(12)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .s_len_type(s_len_type), .gmii_txd(gmii_txd),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .busy(busy)
  );

  typedef struct packed {
    logic       rdy;
    logic       er;
    logic       en;
    logic [7:0] d;
  } smp_t;

  smp_t       mon[$];
  bit         rec = 1'b0;
  logic [7:0] pay_buf [0:1600];

  always @(negedge clk) if (rec) mon.push_back({s_ready, gmii_tx_er, gmii_tx_en, gmii_txd});

  function automatic int next_en(int from);
    for (int i = from; i < mon.size(); i++) if (mon[i].en) return i;
    return -1;
  endfunction

  function automatic int run_len(int s);
    int k = 0;
    if (s < 0) return 0;
    while (s + k < mon.size() && mon[s + k].en) k++;
    return k;
  endfunction

  function automatic int count_en();
    int c = 0;
    foreach (mon[i]) if (mon[i].en) c++;
    return c;
  endfunction

  function automatic int count_er();
    int c = 0;
    foreach (mon[i]) if (mon[i].er) c++;
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(int idx, int n, logic [15:0] lt);
    logic [47:0] t;
    if (idx < 7) return 8'h55;
    if (idx == 7) return 8'hD5;
    if (idx < 14) begin t = 48'h023528fbdd66 << (8 * (idx - 8)); return t[47:40]; end
    if (idx < 20) begin t = 48'h072227acdb65 << (8 * (idx - 14)); return t[47:40]; end
    if (idx == 20) return lt[15:8];
    if (idx == 21) return lt[7:0];
    if (idx - 22 < n) return pay_buf[idx - 22];
    return 8'h00;
  endfunction

  function automatic int first_bad(int s, int cnt, int n, logic [15:0] lt);
    if (s < 0) return 0;
    for (int o = 0; o < cnt; o++) begin
      if (s + o >= mon.size()) return o;
      if (mon[s + o].d !== exp_byte(o, n, lt)) return o;
    end
    return -1;
  endfunction

  // zlib-style CRC-32 over captured bytes; over data plus its FCS it yields the fixed residue.
  function automatic logic [31:0] crc_over(int s, int cnt);
    logic [31:0] c = 32'hFFFFFFFF;
    if (s < 0) return 32'h0;
    for (int i = s; i < s + cnt && i < mon.size(); i++) begin
      c = c ^ {24'h000000, mon[i].d};
      for (int b = 0; b < 8; b++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
    end
    return ~c;
  endfunction

  task automatic send_frame(input int n, input logic [15:0] lt, input int drop_at, output bit done);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    s_len_type = lt;
    s_valid    = 1'b1;
    s_data     = pay_buf[0];
    s_last     = (n == 1);
    while (i < n && guard < 4 * n + 200) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        i++;
        if (i == drop_at) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
          s_valid = 1'b1;
        end
        if (i < n) begin
          s_data = pay_buf[i];
          s_last = (i == n - 1);
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    done    = (i == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (gmii_txd !== 8'h00) begin n_bad++; $display("FAIL reset_txd: got %h expected 00", gmii_txd); end
    n_cmp++; if (gmii_tx_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b expected 0", gmii_tx_en); end
    n_cmp++; if (gmii_tx_er !== 1'b0) begin n_bad++; $display("FAIL reset_er: got %b expected 0", gmii_tx_er); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", s_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int s, len, fb;
    bit done;
    for (int i = 0; i < 60; i++) pay_buf[i] = 8'(i);
    @(posedge clk); #1;
    mon.delete(); rec = 1'b1;
    send_frame(60, 16'h003C, -1, done);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rec = 1'b0;
    s = next_en(0); len = run_len(s); fb = first_bad(s, 82, 60, 16'h003C);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL nominal_accept: got %b expected 1", done); end
    n_cmp++; if (s !== 2) begin n_bad++; $display("FAIL nominal_latency: got %0d expected 2", s); end
    n_cmp++; if (len !== 82 + FCSN) begin n_bad++; $display("FAIL nominal_len: got %0d expected %0d", len, 82 + FCSN); end
    n_cmp++; if (count_en() !== len) begin n_bad++; $display("FAIL nominal_contig: got %0d expected %0d", count_en(), len); end
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL nominal_bytes: first bad offset %0d expected none", fb); end
    n_cmp++; if (count_er() !== 0) begin n_bad++; $display("FAIL nominal_er: got %0d expected 0", count_er()); end
`ifdef ETH_TX_FCS_EN
    n_cmp++; if (crc_over(s + 8, 78) !== 32'h2144DF1C) begin n_bad++; $display("FAIL nominal_fcs: got %h expected 2144df1c", crc_over(s + 8, 78)); end
`endif
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nominal_idle: got %b expected 0", busy); end
  endtask

  task automatic test_short_pad();
    int s, len, fb;
    bit done;
    pay_buf[0] = 8'hAB;
    @(posedge clk); #1;
    mon.delete(); rec = 1'b1;
    send_frame(1, 16'h0001, -1, done);
    for (int k = 0; k < 300 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rec = 1'b0;
    s = next_en(0); len = run_len(s); fb = first_bad(s, 68, 1, 16'h0001);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL short_accept: got %b expected 1", done); end
    n_cmp++; if (len !== 68 + FCSN) begin n_bad++; $display("FAIL short_len: got %0d expected %0d", len, 68 + FCSN); end
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL short_pad_bytes: first bad offset %0d expected none", fb); end
`ifdef ETH_TX_FCS_EN
    n_cmp++; if (crc_over(s + 8, 64) !== 32'h2144DF1C) begin n_bad++; $display("FAIL short_fcs: got %h expected 2144df1c", crc_over(s + 8, 64)); end
`endif
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL short_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int s1, l1, s2, l2, gap, rdy_in_gap, fb;
    bit d1, d2;
    for (int i = 0; i < 60; i++) pay_buf[i] = 8'(i);
    @(posedge clk); #1;
    mon.delete(); rec = 1'b1;
    send_frame(60, 16'h003C, -1, d1);
    send_frame(60, 16'h0800, -1, d2);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rec = 1'b0;
    s1 = next_en(0); l1 = run_len(s1);
    s2 = next_en(s1 + l1); l2 = run_len(s2);
    gap = s2 - (s1 + l1);
    rdy_in_gap = 0;
    for (int i = s1 + l1; i < s2; i++) if (mon[i].rdy) rdy_in_gap++;
    fb = first_bad(s2, 82, 60, 16'h0800);
    n_cmp++; if ({d1, d2} !== 2'b11) begin n_bad++; $display("FAIL b2b_accept: got %b expected 11", {d1, d2}); end
    n_cmp++; if (gap !== 12) begin n_bad++; $display("FAIL b2b_gap: got %0d expected 12", gap); end
    n_cmp++; if (rdy_in_gap !== 0) begin n_bad++; $display("FAIL b2b_ready_in_gap: got %0d expected 0", rdy_in_gap); end
    n_cmp++; if (l2 !== 82 + FCSN) begin n_bad++; $display("FAIL b2b_len2: got %0d expected %0d", l2, 82 + FCSN); end
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL b2b_bytes2: first bad offset %0d expected none", fb); end
  endtask

  task automatic test_underrun();
    int s, len, fb;
    bit done;
    for (int i = 0; i < 60; i++) pay_buf[i] = 8'(i + 8'h40);
    @(posedge clk); #1;
    mon.delete(); rec = 1'b1;
    send_frame(60, 16'h003C, 10, done);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rec = 1'b0;
    s = next_en(0); len = run_len(s); fb = first_bad(s, 32, 60, 16'h003C);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL underrun_consume: got %b expected 1", done); end
    n_cmp++; if (len !== 33) begin n_bad++; $display("FAIL underrun_len: got %0d expected 33", len); end
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL underrun_bytes: first bad offset %0d expected none", fb); end
    n_cmp++;
    if (s < 0 || mon[s + 32] !== {1'b1, 1'b1, 1'b1, 8'h00} && mon[s + 32] !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL underrun_err_cycle: got er/en/txd %b/%b/%h expected 1/1/00",
                        (s < 0) ? 1'bx : mon[s + 32].er, (s < 0) ? 1'bx : mon[s + 32].en, (s < 0) ? 8'hxx : mon[s + 32].d);
    end
    n_cmp++; if (count_en() !== 33) begin n_bad++; $display("FAIL underrun_no_output: got %0d en cycles expected 33", count_en()); end
    n_cmp++; if (count_er() !== 1) begin n_bad++; $display("FAIL underrun_er_count: got %0d expected 1", count_er()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL underrun_idle: got %b expected 0", busy); end
  endtask

  task automatic test_oversize();
    int s, len, fb, s2, l2, fb2;
    bit d1, d2;
    for (int i = 0; i < 1501; i++) pay_buf[i] = 8'(i * 7);
    @(posedge clk); #1;
    mon.delete(); rec = 1'b1;
    send_frame(1501, 16'h05DD, -1, d1);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    for (int i = 0; i < 60; i++) pay_buf[i] = 8'(i);
    send_frame(60, 16'h003C, -1, d2);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rec = 1'b0;
    s = next_en(0); len = run_len(s);
    for (int i = 0; i < 1501; i++) pay_buf[i] = 8'(i * 7);
    fb = first_bad(s, 1522, 1501, 16'h05DD);
    n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL oversize_consume: got %b expected 1", d1); end
    n_cmp++; if (len !== 1523) begin n_bad++; $display("FAIL oversize_len: got %0d expected 1523", len); end
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL oversize_bytes: first bad offset %0d expected none", fb); end
    n_cmp++;
    if (s < 0 || mon[s + 1522].er !== 1'b1) begin
      n_bad++; $display("FAIL oversize_err_cycle: got er %b expected 1", (s < 0) ? 1'bx : mon[s + 1522].er);
    end
    n_cmp++; if (count_er() !== 1) begin n_bad++; $display("FAIL oversize_er_count: got %0d expected 1", count_er()); end
    for (int i = 0; i < 60; i++) pay_buf[i] = 8'(i);
    s2 = next_en(s + len); l2 = run_len(s2); fb2 = first_bad(s2, 82, 60, 16'h003C);
    n_cmp++; if (d2 !== 1'b1) begin n_bad++; $display("FAIL oversize_next_accept: got %b expected 1", d2); end
    n_cmp++; if (l2 !== 82 + FCSN) begin n_bad++; $display("FAIL oversize_next_len: got %0d expected %0d", l2, 82 + FCSN); end
    n_cmp++; if (fb2 !== -1) begin n_bad++; $display("FAIL oversize_next_bytes: first bad offset %0d expected none", fb2); end
`ifdef ETH_TX_FCS_EN
    n_cmp++; if (crc_over(s2 + 8, 78) !== 32'h2144DF1C) begin n_bad++; $display("FAIL oversize_next_fcs: got %h expected 2144df1c", crc_over(s2 + 8, 78)); end
`endif
  endtask

  task automatic test_rst_mid_frame();
    int s, len, fb;
    bit done;
    @(posedge clk); #1;
    s_len_type = 16'h0800; s_data = 8'h00; s_last = 1'b0; s_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    n_cmp++; if (gmii_tx_en !== 1'b1) begin n_bad++; $display("FAIL rst_pre_en: got %b expected 1", gmii_tx_en); end
    #1; rst = 1'b1; #1;
    n_cmp++;
    if ({gmii_txd, gmii_tx_en, gmii_tx_er, busy, s_ready} !== 12'h000) begin
      n_bad++; $display("FAIL rst_async_clear: got txd/en/er/busy/rdy %h/%b/%b/%b/%b expected 00/0/0/0/0",
                        gmii_txd, gmii_tx_en, gmii_tx_er, busy, s_ready);
    end
    s_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 60; i++) pay_buf[i] = 8'(8'hC0 ^ i);
    repeat (2) @(posedge clk);
    #1;
    mon.delete(); rec = 1'b1;
    send_frame(60, 16'h003C, -1, done);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rec = 1'b0;
    s = next_en(0); len = run_len(s); fb = first_bad(s, 82, 60, 16'h003C);
    n_cmp++; if (s !== 2) begin n_bad++; $display("FAIL rst_restart_latency: got %0d expected 2", s); end
    n_cmp++; if (len !== 82 + FCSN) begin n_bad++; $display("FAIL rst_restart_len: got %0d expected %0d", len, 82 + FCSN); end
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL rst_restart_bytes: first bad offset %0d expected none", fb); end
`ifdef ETH_TX_FCS_EN
    n_cmp++; if (crc_over(s + 8, 78) !== 32'h2144DF1C) begin n_bad++; $display("FAIL rst_restart_fcs: got %h expected 2144df1c", crc_over(s + 8, 78)); end
`endif
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_len_type = '0;
    test_reset();
    test_nominal();
    test_short_pad();
    test_back_to_back();
    test_underrun();
    test_oversize();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
